// File: rtl/baseline_trigger.sv
// baseline_trigger: subtracts the IIR baseline from the raw ADC stream,
// discriminates pulses against THRESH and emits one event record (peak,
// area, length, truncation flag) per pulse over a valid/ready handshake.
// Optional build macro NEG_PULSE_EN: when defined, the difference is
// base - adc so that negative-going pulses are detected.
module baseline_trigger #(
  parameter int THRESH  = 16,
  parameter int HOLDOFF = 8,
  parameter int MAX_LEN = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [13:0] adc,
  input  logic [40:0] avr_whole,
  input  logic [40:0] avr_frac,
  input  logic        avr_valid,
  output logic        trig,
  output logic        evt_valid,
  input  logic        evt_ready,
  output logic [14:0] evt_peak,
  output logic [23:0] evt_area,
  output logic [7:0]  evt_len,
  output logic        evt_trunc,
  output logic [15:0] lost_cnt
);

  localparam logic signed [14:0] THRESH_S  = 15'(THRESH);
  localparam logic        [7:0]  MAX_LEN_C = 8'(MAX_LEN);
  localparam logic        [7:0]  HOLDOFF_C = 8'(HOLDOFF);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMED,
    ST_PULSE,
    ST_HOLD
  } state_t;

  state_t             state_q;
  logic [13:0]        base_lat_q;
  logic signed [14:0] peak_q;
  logic [23:0]        area_q;
  logic [7:0]         len_q;
  logic [7:0]         hold_q;
  logic               trig_q;

  logic               evt_valid_q;
  logic [14:0]        evt_peak_q;
  logic [23:0]        evt_area_q;
  logic [7:0]         evt_len_q;
  logic               evt_trunc_q;
  logic [15:0]        lost_q;

  logic [14:0]        base_sum_d;
  logic [13:0]        base_live_d;
  logic [13:0]        base_use_d;
  logic signed [14:0] diff_d;
  logic               above_d;
  logic               room_d;
  logic               end_pulse_d;
  logic [23:0]        area_sum_d;

  // Only the top fraction bit participates in rounding; the rest is ignored.
  logic unused_frac;
  assign unused_frac = ^{avr_frac[40:15], avr_frac[13:0]};

  // Live baseline: round half up, saturating to full scale when the integer
  // part exceeds 14 bits or the rounding carries out.
  always_comb begin
    base_sum_d  = {1'b0, avr_whole[13:0]} + {14'd0, avr_frac[14]};
    base_live_d = base_sum_d[13:0];
    if ((|avr_whole[40:14]) || base_sum_d[14]) begin
      base_live_d = 14'h3FFF;
    end
  end

  // Inside a pulse and its hold-off the baseline frozen at pulse start is used.
  assign base_use_d = ((state_q == ST_PULSE) || (state_q == ST_HOLD)) ? base_lat_q : base_live_d;

`ifdef NEG_PULSE_EN
  assign diff_d = $signed({1'b0, base_use_d}) - $signed({1'b0, adc});
`else
  assign diff_d = $signed({1'b0, adc}) - $signed({1'b0, base_use_d});
`endif

  assign above_d     = (diff_d > THRESH_S);
  assign room_d      = (len_q < MAX_LEN_C);
  assign area_sum_d  = area_q + {{9{diff_d[14]}}, diff_d};
  // A pulse ends when the sample falls to threshold or the length limit is
  // reached; losing avr_valid discards the pulse instead of ending it.
  assign end_pulse_d = avr_valid && (state_q == ST_PULSE) && !(above_d && room_d);

  // Discriminator FSM: arming, pulse accumulation, hold-off and trig strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      base_lat_q <= '0;
      peak_q     <= '0;
      area_q     <= '0;
      len_q      <= '0;
      hold_q     <= '0;
      trig_q     <= 1'b0;
    end else begin
      trig_q <= 1'b0;
      if (!avr_valid) begin
        state_q <= ST_IDLE;
        peak_q  <= '0;
        area_q  <= '0;
        len_q   <= '0;
        hold_q  <= '0;
      end else begin
        unique case (state_q)
          ST_IDLE: begin
            state_q <= ST_ARMED;
          end
          ST_ARMED: begin
            if (above_d) begin
              state_q    <= ST_PULSE;
              base_lat_q <= base_live_d;
              peak_q     <= diff_d;
              area_q     <= {{9{diff_d[14]}}, diff_d};
              len_q      <= 8'd1;
              trig_q     <= 1'b1;
            end
          end
          ST_PULSE: begin
            if (above_d && room_d) begin
              area_q <= area_sum_d;
              len_q  <= len_q + 8'd1;
              if (diff_d > peak_q) begin
                peak_q <= diff_d;
              end
            end else begin
              state_q <= ST_HOLD;
              hold_q  <= HOLDOFF_C;
            end
          end
          ST_HOLD: begin
            if (hold_q <= 8'd1) begin
              hold_q  <= '0;
              state_q <= ST_ARMED;
            end else begin
              hold_q <= hold_q - 8'd1;
            end
          end
          default: begin
            state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end

  // Event record register: publish on pulse end if the slot is free (or being
  // freed this cycle), otherwise count the drop; clear valid on acceptance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      evt_valid_q <= 1'b0;
      evt_peak_q  <= '0;
      evt_area_q  <= '0;
      evt_len_q   <= '0;
      evt_trunc_q <= 1'b0;
      lost_q      <= '0;
    end else if (end_pulse_d) begin
      if (!evt_valid_q || evt_ready) begin
        evt_valid_q <= 1'b1;
        evt_peak_q  <= $unsigned(peak_q);
        evt_area_q  <= area_q;
        evt_len_q   <= len_q;
        evt_trunc_q <= above_d;
      end else if (lost_q != 16'hFFFF) begin
        lost_q <= lost_q + 16'd1;
      end
    end else if (evt_valid_q && evt_ready) begin
      evt_valid_q <= 1'b0;
    end
  end

  assign trig      = trig_q;
  assign evt_valid = evt_valid_q;
  assign evt_peak  = evt_peak_q;
  assign evt_area  = evt_area_q;
  assign evt_len   = evt_len_q;
  assign evt_trunc = evt_trunc_q;
  assign lost_cnt  = lost_q;

endmodule

// File: tb/tb_baseline_trigger.sv
// Directed testbench for baseline_trigger (THRESH=16, HOLDOFF=8, MAX_LEN=64).
module tb_baseline_trigger;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [13:0] adc = '0;
  logic [40:0] avr_whole = '0;
  logic [40:0] avr_frac = '0;
  logic        avr_valid = 1'b0;
  logic        trig;
  logic        evt_valid;
  logic        evt_ready = 1'b0;
  logic [14:0] evt_peak;
  logic [23:0] evt_area;
  logic [7:0]  evt_len;
  logic        evt_trunc;
  logic [15:0] lost_cnt;

  int checks = 0;
  int fails  = 0;

  baseline_trigger #(.THRESH(16), .HOLDOFF(8), .MAX_LEN(64)) dut (
    .clk(clk), .rst(rst), .adc(adc), .avr_whole(avr_whole), .avr_frac(avr_frac),
    .avr_valid(avr_valid), .trig(trig), .evt_valid(evt_valid), .evt_ready(evt_ready),
    .evt_peak(evt_peak), .evt_area(evt_area), .evt_len(evt_len), .evt_trunc(evt_trunc),
    .lost_cnt(lost_cnt)
  );

  always #5 clk = ~clk;

  // one clock edge, then settle so outputs are sampled away from the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    adc = 14'd1000;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic accept();
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; avr_valid = 1'b1; avr_whole = 41'd1000; avr_frac = '0; adc = 14'd1000;
    tick(); tick();
    checks++;
    if ({trig, evt_valid, evt_peak, evt_area, evt_len, evt_trunc, lost_cnt} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got trig=%0b valid=%0b peak=%0d area=%0d len=%0d trunc=%0b lost=%0d required all 0",
               trig, evt_valid, evt_peak, evt_area, evt_len, evt_trunc, lost_cnt);
    end
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (trig !== 1'b0 || evt_valid !== 1'b0 || lost_cnt !== 16'd0) begin
        fails++;
        $display("FAIL quiet_baseline cycle %0d: got trig=%0b valid=%0b lost=%0d required 0/0/0", i, trig, evt_valid, lost_cnt);
      end
    end
    $display("reset/quiet: %0d cycles at baseline, no trigger expected", 20);
  endtask

  task automatic test_threshold();
    adc = 14'd1016; tick();
    checks++;
    if (trig !== 1'b0) begin fails++; $display("FAIL thresh_equal_no_trig: got %0b required 0", trig); end
    adc = 14'd1017; tick();
    checks++;
    if (trig !== 1'b1) begin fails++; $display("FAIL thresh_plus1_trig: got %0b required 1", trig); end
    adc = 14'd1000; tick();
    checks++;
    if (evt_valid !== 1'b1 || evt_peak !== 15'd17 || evt_area !== 24'd17 || evt_len !== 8'd1 || evt_trunc !== 1'b0) begin
      fails++;
      $display("FAIL thresh_record: got v=%0b peak=%0d area=%0d len=%0d trunc=%0b required 1/17/17/1/0",
               evt_valid, evt_peak, evt_area, evt_len, evt_trunc);
    end
    $display("record: peak=%0d area=%0d len=%0d trunc=%0b", evt_peak, evt_area, evt_len, evt_trunc);
    accept();
    idle(10);
  endtask

  task automatic test_rounded_pulse();
    avr_frac = 41'd16384; adc = 14'd1001; tick();
    checks++;
    if (trig !== 1'b0) begin fails++; $display("FAIL round_no_trig: got %0b required 0", trig); end
    adc = 14'd1020; tick();
    checks++;
    if (trig !== 1'b1) begin fails++; $display("FAIL round_trig: got %0b required 1", trig); end
    adc = 14'd1060; tick();
    checks++;
    if (trig !== 1'b0) begin fails++; $display("FAIL round_trig_one_cycle: got %0b required 0", trig); end
    adc = 14'd1030; tick();
    adc = 14'd1001; tick();
    checks++;
    if (evt_valid !== 1'b1 || evt_peak !== 15'd59 || evt_area !== 24'd107 || evt_len !== 8'd3 || evt_trunc !== 1'b0) begin
      fails++;
      $display("FAIL round_record: got v=%0b peak=%0d area=%0d len=%0d trunc=%0b required 1/59/107/3/0",
               evt_valid, evt_peak, evt_area, evt_len, evt_trunc);
    end
    $display("record: peak=%0d area=%0d len=%0d trunc=%0b", evt_peak, evt_area, evt_len, evt_trunc);
    accept();
    checks++;
    if (evt_valid !== 1'b0) begin fails++; $display("FAIL round_accept: got valid=%0b required 0", evt_valid); end
    avr_frac = '0;
    idle(10);
  endtask

  task automatic test_truncation();
    adc = 14'd1100; tick();
    checks++;
    if (trig !== 1'b1) begin fails++; $display("FAIL trunc_trig1: got %0b required 1", trig); end
    for (int i = 2; i <= 64; i++) tick();
    checks++;
    if (evt_valid !== 1'b0) begin fails++; $display("FAIL trunc_early_record: got valid=%0b required 0", evt_valid); end
    tick();
    checks++;
    if (evt_valid !== 1'b1 || evt_peak !== 15'd100 || evt_area !== 24'd6400 || evt_len !== 8'd64 || evt_trunc !== 1'b1) begin
      fails++;
      $display("FAIL trunc_record: got v=%0b peak=%0d area=%0d len=%0d trunc=%0b required 1/100/6400/64/1",
               evt_valid, evt_peak, evt_area, evt_len, evt_trunc);
    end
    $display("record: peak=%0d area=%0d len=%0d trunc=%0b", evt_peak, evt_area, evt_len, evt_trunc);
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++;
      if (trig !== 1'b0) begin fails++; $display("FAIL holdoff_no_trig cycle %0d: got %0b required 0", i, trig); end
    end
    tick();
    checks++;
    if (trig !== 1'b1) begin fails++; $display("FAIL holdoff_retrig: got %0b required 1", trig); end
    accept();
    checks++;
    if (evt_valid !== 1'b0) begin fails++; $display("FAIL trunc_accept: got valid=%0b required 0", evt_valid); end
    adc = 14'd1000; tick();
    checks++;
    if (evt_valid !== 1'b1 || evt_peak !== 15'd100 || evt_area !== 24'd200 || evt_len !== 8'd2 || evt_trunc !== 1'b0) begin
      fails++;
      $display("FAIL retrig_record: got v=%0b peak=%0d area=%0d len=%0d trunc=%0b required 1/100/200/2/0",
               evt_valid, evt_peak, evt_area, evt_len, evt_trunc);
    end
    $display("record: peak=%0d area=%0d len=%0d trunc=%0b", evt_peak, evt_area, evt_len, evt_trunc);
    accept();
    idle(10);
  endtask

  task automatic test_back_to_back();
    evt_ready = 1'b0;
    adc = 14'd1050; tick(); tick();
    adc = 14'd1000; tick();
    idle(10);
    adc = 14'd1030; tick();
    adc = 14'd1000; tick();
    checks++;
    if (evt_valid !== 1'b1 || evt_peak !== 15'd50 || evt_area !== 24'd100 || evt_len !== 8'd2 || lost_cnt !== 16'd1) begin
      fails++;
      $display("FAIL b2b_retained: got v=%0b peak=%0d area=%0d len=%0d lost=%0d required 1/50/100/2/1",
               evt_valid, evt_peak, evt_area, evt_len, lost_cnt);
    end
    $display("record: peak=%0d area=%0d len=%0d lost=%0d", evt_peak, evt_area, evt_len, lost_cnt);
    accept();
    checks++;
    if (evt_valid !== 1'b0) begin fails++; $display("FAIL b2b_accept: got valid=%0b required 0", evt_valid); end
    idle(10);
  endtask

  task automatic test_valid_drop();
    adc = 14'd1100;
    for (int i = 0; i < 5; i++) tick();
    avr_valid = 1'b0; tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (trig !== 1'b0 || evt_valid !== 1'b0 || lost_cnt !== 16'd1) begin
        fails++;
        $display("FAIL drop_discard cycle %0d: got trig=%0b valid=%0b lost=%0d required 0/0/1", i, trig, evt_valid, lost_cnt);
      end
    end
    avr_valid = 1'b1; tick();
    checks++;
    if (trig !== 1'b0) begin fails++; $display("FAIL drop_rearm_wait: got %0b required 0", trig); end
    tick();
    checks++;
    if (trig !== 1'b1) begin fails++; $display("FAIL drop_rearm_trig: got %0b required 1", trig); end
    adc = 14'd1000; tick();
    checks++;
    if (evt_valid !== 1'b1 || evt_peak !== 15'd100 || evt_area !== 24'd100 || evt_len !== 8'd1 || lost_cnt !== 16'd1) begin
      fails++;
      $display("FAIL drop_record: got v=%0b peak=%0d area=%0d len=%0d lost=%0d required 1/100/100/1/1",
               evt_valid, evt_peak, evt_area, evt_len, lost_cnt);
    end
    $display("record: peak=%0d area=%0d len=%0d lost=%0d", evt_peak, evt_area, evt_len, lost_cnt);
    idle(10);
  endtask

  task automatic test_saturation();
    avr_whole = 41'd16383; avr_frac = 41'd16384; adc = 14'd16383;
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if (trig !== 1'b0 || evt_valid !== 1'b1) begin
      fails++; $display("FAIL sat_round_overflow: got trig=%0b valid=%0b required 0/1", trig, evt_valid);
    end
    avr_whole = 41'd16389; avr_frac = '0;
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if (trig !== 1'b0) begin fails++; $display("FAIL sat_whole_high: got %0b required 0", trig); end
    avr_whole = 41'd1000;
    idle(3);
    $display("saturation: base clamped to 16383 for adc=16383");
  endtask

  task automatic test_reset_mid();
    adc = 14'd1100; tick();
    checks++;
    if (trig !== 1'b1) begin fails++; $display("FAIL rstmid_trig: got %0b required 1", trig); end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (trig !== 1'b0 || evt_valid !== 1'b0 || lost_cnt !== 16'd0) begin
      fails++;
      $display("FAIL rstmid_clear: got trig=%0b valid=%0b lost=%0d required 0/0/0", trig, evt_valid, lost_cnt);
    end
    tick();
    rst = 1'b0;
    idle(2);
  endtask

`ifdef NEG_PULSE_EN
  task automatic test_neg_pulse();
    avr_whole = 41'd8000; adc = 14'd8000; tick(); tick();
    adc = 14'd7900; tick();
    checks++;
    if (trig !== 1'b1) begin fails++; $display("FAIL neg_trig: got %0b required 1", trig); end
    tick();
    adc = 14'd8000; tick();
    checks++;
    if (evt_valid !== 1'b1 || evt_peak !== 15'd100 || evt_area !== 24'd200 || evt_len !== 8'd2) begin
      fails++;
      $display("FAIL neg_record: got v=%0b peak=%0d area=%0d len=%0d required 1/100/200/2",
               evt_valid, evt_peak, evt_area, evt_len);
    end
    $display("record: peak=%0d area=%0d len=%0d", evt_peak, evt_area, evt_len);
  endtask
`endif

  initial begin
    test_reset();
`ifdef NEG_PULSE_EN
    test_neg_pulse();
`else
    test_threshold();
    test_rounded_pulse();
    test_truncation();
    test_back_to_back();
    test_valid_drop();
    test_saturation();
    test_reset_mid();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
